// File: rtl/uart_pkg.sv
// Shared definitions for the debug/loopback serial link (uart_tx / uart_rx).
package uart_pkg;

  // Receiver FSM state encoding (2 bits)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // clk cycles per bit, shared by transmitter and receiver
  localparam int BAUD_CNT_MAX_DEFAULT = 56;

  // Width of the baud counter; covers divisors up to 16384
  localparam int CNT_W = 14;

  // Payload bits per frame (8N1)
  localparam int DATA_BITS = 8;

  // Bit counter width for DATA_BITS payload bits
  localparam int BIT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a delayed
// copy used to detect the falling edge of the start bit. All flops reset
// to the idle-high line level so reset release never looks like an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_edge
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;

  // Resynchronise rx_in into clk and keep one cycle of history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg   <= 1'b1;
      sync_reg   <= 1'b1;
      sync_d_reg <= 1'b1;
    end else begin
      meta_reg   <= rx_in;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
    end
  end

  assign rx_s      = sync_reg;
  assign fall_edge = sync_d_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects a start edge, confirms the start bit at
// mid-period, shifts in eight data bits LSB first, then checks the stop
// bit and issues either a data-valid or a framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEFAULT,
  parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF_CNT);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 fall_edge;

  logic [1:0]           state_reg,     state_next;
  logic [CNT_W-1:0]     baud_cnt_reg,  baud_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg,   bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,     shift_next;
  logic [7:0]           rx_data_reg,   rx_data_next;
  logic                 rx_valid_reg,  rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 sample;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  // Mid-bit sampling point, valid in every non-idle state
  assign sample = (state_reg != IDLE) && (baud_cnt_reg == HALF_C);

  // Next-state, shift and strobe logic
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            // Line back high at mid start bit: treat as a glitch
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          // Leave mid stop bit so a back-to-back start edge is not missed
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Baud counter: parked at zero in IDLE, free-running modulo BAUD_CNT_MAX otherwise
  always_comb begin
    if (state_reg == IDLE || state_next == IDLE) begin
      baud_cnt_next = '0;
    end else if (baud_cnt_reg == LAST_C) begin
      baud_cnt_next = '0;
    end else begin
      baud_cnt_next = baud_cnt_reg + 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level model (expected byte / error and strobe time).
module tb_uart_rx;

  localparam int MAX  = 56;
  localparam int HALF = MAX / 2;
  // Two synchroniser flops plus the registered edge put the first START
  // cycle 3 clocks after the line falls; the strobe follows the stop sample.
  localparam int LAT  = 3 + HALF + 9 * MAX + 1;

  logic       clk;
  logic       reset_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    int         at;
    bit         err;
    bit         val;
    logic [7:0] data;
  } ev_t;

  ev_t ev_q[$];

  uart_rx #(.BAUD_CNT_MAX(MAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      ev_t e;
      e.at   = cyc;
      e.err  = frame_err;
      e.val  = rx_valid;
      e.data = rx_data;
      ev_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame from a negedge; t0 is the cycle the start bit begins
  task automatic send_frame(input logic [7:0] d, input bit stop, output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (MAX) @(negedge clk);
    end
  endtask

  // Expect the next recorded strobe to match the frame-level prediction
  task automatic expect_ev(input string tag, input int t0, input bit exp_err,
                           input logic [7:0] exp_data);
    ev_t e;
    while (cyc < t0 + LAT + 2) @(negedge clk);
    check({tag, "_present"}, 32'(ev_q.size() > 0), 32'd1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check({tag, "_cycle"}, 32'(e.at), 32'(t0 + LAT));
      check({tag, "_valid"}, 32'(e.val), 32'(!exp_err));
      check({tag, "_ferr"},  32'(e.err), 32'(exp_err));
      check({tag, "_data"},  32'(e.data), 32'(exp_data));
      $display("[TB] %s: t0=%0d strobe@%0d err=%0d data=%02h", tag, t0, e.at, e.err, e.data);
    end
  endtask

  initial begin
    int         t0;
    int         t1;
    int         bad;
    logic [7:0] last_good;
    logic [7:0] d;
    bit         stop;
    int         gap;

    tests     = 0;
    fails     = 0;
    last_good = 8'h00;
    reset_n   = 1'b0;
    rx_in     = 1'b1;

    // Reset and idle line
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    check("rst_busy",  32'(rx_busy),   32'd0);
    check("rst_valid", 32'(rx_valid),  32'd0);
    check("rst_ferr",  32'(frame_err), 32'd0);
    check("rst_data",  32'(rx_data),   32'h00);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_busy || rx_valid || frame_err || rx_data !== 8'h00) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);
    $display("[TB] idle 1000 cycles: bad=%0d", bad);

    // Single good frame
    send_frame(8'hA5, 1'b1, t0);
    last_good = 8'hA5;
    expect_ev("a5", t0, 1'b0, last_good);

    // 10-cycle glitch: START entered, rejected at sample 0
    repeat (20) @(negedge clk);
    t0 = cyc;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", 32'(rx_busy), 32'd1);
    repeat (6) @(negedge clk);
    rx_in = 1'b1;
    while (cyc < t0 + 3 + 30) @(negedge clk);
    check("glitch_busy_lo", 32'(rx_busy), 32'd0);
    repeat (600) @(negedge clk);
    check("glitch_no_strobe", 32'(ev_q.size()), 32'd0);
    $display("[TB] glitch: busy released, strobes=%0d", ev_q.size());

    // Good 5A then 3C with a low stop bit
    send_frame(8'h5A, 1'b1, t0);
    last_good = 8'h5A;
    expect_ev("5a", t0, 1'b0, last_good);
    send_frame(8'h3C, 1'b0, t0);
    rx_in = 1'b1;
    expect_ev("3c_ferr", t0, 1'b1, last_good);
    repeat (20) @(negedge clk);

    // Loopback-style back-to-back 00 then FF
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    expect_ev("b2b_00", t0, 1'b0, 8'h00);
    last_good = 8'hFF;
    expect_ev("b2b_ff", t1, 1'b0, 8'hFF);
    repeat (20) @(negedge clk);

    // Break: line held low gives one frame error only
    t0 = cyc;
    rx_in = 1'b0;
    repeat (2000) @(negedge clk);
    expect_ev("break", t0, 1'b1, last_good);
    check("break_single", 32'(ev_q.size()), 32'd0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of DATA of frame C3
    rx_in = 1'b0;
    repeat (MAX) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * MAX) @(negedge clk);
    rx_in = 1'b0;
    repeat (MAX / 2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy",  32'(rx_busy),   32'd0);
    check("midrst_valid", 32'(rx_valid),  32'd0);
    check("midrst_ferr",  32'(frame_err), 32'd0);
    check("midrst_data",  32'(rx_data),   32'h00);
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (700) @(negedge clk);
    check("midrst_no_strobe", 32'(ev_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, t0);
    last_good = 8'h81;
    expect_ev("after_rst_81", t0, 1'b0, last_good);

    // Random frames with occasional bad stop bits and random gaps
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap  = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 40));
      if (!stop && gap < 8) gap = 8;
      send_frame(d, stop, t0);
      if (stop) last_good = d;
      rx_in = 1'b1;
      expect_ev($sformatf("rnd%0d", k), t0, !stop, last_good);
      repeat (gap) @(negedge clk);
    end

    repeat (700) @(negedge clk);
    check("final_no_extra", 32'(ev_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
